// File: rtl/leakage_window_accumulator.sv
// -----------------------------------------------------------------------------
// leakage_window_accumulator
//
// Collects a fixed window of 2**WIN_LOG2 hamming_sum leakage samples over a
// valid/ready handshake and reports sum, mean, max and min for the window.
// One window per start pulse; results are held until the consumer takes them.
// A start coincident with the result handshake opens the next window at once.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       begin a new window (honoured in IDLE, or in HOLD with out_ready)
//   in_valid    hamming_in carries a sample this cycle
//   in_ready    block accepts a sample this cycle (registered, high in ACCUM)
//   hamming_in  leakage sample, HW_W bits
//   out_valid   window result available
//   out_ready   consumer takes the result this cycle
//   acc_sum     sum of the window samples, ACC_W bits
//   acc_mean    acc_sum >> WIN_LOG2, truncated
//   acc_max     largest sample seen in the window
//   acc_min     smallest sample seen in the window
//   sample_cnt  samples accepted in the current window
//   busy        high in ACCUM and HOLD
// -----------------------------------------------------------------------------
module leakage_window_accumulator #(
    parameter int HW_W     = 4,
    parameter int WIN_LOG2 = 4,
    parameter int ACC_W    = HW_W + WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [HW_W-1:0]     hamming_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    acc_sum,
    output logic [HW_W-1:0]     acc_mean,
    output logic [HW_W-1:0]     acc_max,
    output logic [HW_W-1:0]     acc_min,
    output logic [WIN_LOG2:0]   sample_cnt,
    output logic                busy
);

    localparam int WIN = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] LAST_IDX = (WIN_LOG2 + 1)'(WIN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;

    logic accept;
    logic load_window;

    // A new window opens from IDLE on start, or straight out of HOLD when the
    // result is consumed in the same cycle as start (no IDLE bubble).
    always_comb begin
        accept      = (state == ACCUM) && in_valid && in_ready;
        load_window = start && ((state == IDLE) || ((state == HOLD) && out_ready));
    end

    assign acc_mean = HW_W'(acc_sum >> WIN_LOG2);

    // NOTE: every register in this block is assigned with <= so that all of
    // them update from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            acc_sum    <= '0;
            acc_max    <= '0;
            acc_min    <= '0;
            sample_cnt <= '0;
        end else if (load_window) begin
            state      <= ACCUM;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b1;
            acc_sum    <= '0;
            acc_max    <= '0;
            // All-ones so the first sample always becomes the minimum.
            acc_min    <= '1;
            sample_cnt <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_sum    <= acc_sum + ACC_W'(hamming_in);
                        sample_cnt <= sample_cnt + 1'b1;
                        if (hamming_in > acc_max) acc_max <= hamming_in;
                        if (hamming_in < acc_min) acc_min <= hamming_in;
                        // in_ready drops on the same edge that takes the last
                        // sample, so nothing past the window is ever accepted.
                        if (sample_cnt == LAST_IDX) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                IDLE: begin
                    // Results of the last window stay visible here.
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leakage_window_accumulator.sv
// -----------------------------------------------------------------------------
// tb_leakage_window_accumulator
//
// Directed bench for leakage_window_accumulator with hand-computed expected
// values. Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_leakage_window_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] hamming_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] acc_sum;
    logic [3:0] acc_mean;
    logic [3:0] acc_max;
    logic [3:0] acc_min;
    logic [4:0] sample_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    leakage_window_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hamming_in (hamming_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_sum    (acc_sum),
        .acc_mean   (acc_mean),
        .acc_max    (acc_max),
        .acc_min    (acc_min),
        .sample_cnt (sample_cnt),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Optional idle gap, then present one sample and hold it until accepted.
    task automatic send_sample(input logic [3:0] v, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        hamming_in = v;
        in_valid   = 1'b1;
        for (int k = 0; k < 20 && !in_ready; k++) tick();
        if (!in_ready) check("send_ready_timeout", in_ready, 1);
        else tick();
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int sum, input int mean,
                                input int mx, input int mn, input int cnt);
        check({tag, "_sum"},  acc_sum,    sum);
        check({tag, "_mean"}, acc_mean,   mean);
        check({tag, "_max"},  acc_max,    mx);
        check({tag, "_min"},  acc_min,    mn);
        check({tag, "_cnt"},  sample_cnt, cnt);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; hamming_in = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check_result("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // T1: 16 samples of 8, continuous valid.
        pulse_start();
        check("t1_in_ready", in_ready, 1);
        check("t1_busy",     busy,     1);
        check("t1_min_init", acc_min,  15);
        for (int i = 0; i < 15; i++) send_sample(4'd8, 0);
        check("t1_no_valid_early", out_valid, 0);
        send_sample(4'd8, 0);
        check("t1_out_valid", out_valid, 1);
        check("t1_in_ready_drop", in_ready, 0);
        check_result("t1", 128, 8, 8, 8, 16);

        // T3: hold with out_ready low, results stable; then consume.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_ready", in_ready,  0);
            check_result("t3_hold", 128, 8, 8, 8, 16);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t3_idle_valid", out_valid, 0);
        check("t3_idle_ready", in_ready,  0);
        check("t3_idle_busy",  busy,      0);
        check_result("t3_idle", 128, 8, 8, 8, 16);
        tick();
        check("t3_idle_ready2", in_ready, 0);

        // T2: ramp 0..15 with valid gaps, then try to push an extra sample.
        pulse_start();
        for (int i = 0; i < 16; i++) send_sample(4'(i), i % 3);
        check("t2_out_valid", out_valid, 1);
        check("t2_in_ready",  in_ready,  0);
        check_result("t2", 120, 7, 15, 0, 16);
        hamming_in = 4'd15; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_result("t2_extra", 120, 7, 15, 0, 16);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // T4: start pulses during ACCUM are ignored.
        pulse_start();
        for (int i = 0; i < 5; i++) send_sample(4'd3, 0);
        pulse_start();
        check("t4_ignore_cnt", sample_cnt, 5);
        check("t4_ignore_sum", acc_sum,    15);
        check("t4_ignore_rdy", in_ready,   1);
        for (int i = 0; i < 11; i++) begin
            start = (i == 4);
            send_sample(4'd3, 0);
        end
        start = 1'b0;
        check("t4_out_valid", out_valid, 1);
        check_result("t4", 48, 3, 3, 3, 16);

        // T6: start together with out_ready in HOLD -> immediate new window.
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("t6_in_ready",  in_ready,  1);
        check("t6_out_valid", out_valid, 0);
        check("t6_busy",      busy,      1);
        check_result("t6_clear", 0, 0, 0, 15, 0);
        for (int i = 0; i < 16; i++) send_sample(4'd15, 0);
        check("t6_out_valid2", out_valid, 1);
        check_result("t6", 240, 15, 15, 15, 16);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // T5: reset mid-window, then a clean window.
        pulse_start();
        for (int i = 0; i < 7; i++) send_sample(4'd9, 0);
        check("t5_partial_sum", acc_sum, 63);
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; hamming_in = 4'd9;
        tick();
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        check("t5_rst_ready", in_ready,  0);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy",  busy,      0);
        check_result("t5_rst", 0, 0, 0, 0, 0);
        pulse_start();
        for (int i = 0; i < 16; i++) send_sample((i % 2 == 0) ? 4'd2 : 4'd12, 0);
        check("t5_out_valid", out_valid, 1);
        check_result("t5", 112, 7, 12, 2, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Backstop in case the bench itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
